// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word type and memory arbiter state encoding
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    localparam int DSTREAK_W = 3;
    localparam int TCNT_W    = 8;

    function automatic logic [DSTREAK_W-1:0] sat_inc(input logic [DSTREAK_W-1:0] v);
        return (v == {DSTREAK_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter: data priority, bounded fetch starvation, timeout flag
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  halt,

    input  logic  i_req,
    input  word_t i_addr,
    output word_t i_rdata,
    output logic  i_ack,

    input  logic  d_req,
    input  logic  d_wen,
    input  word_t d_addr,
    input  word_t d_wdata,
    output word_t d_rdata,
    output logic  d_ack,

    output logic  ram_req,
    output logic  ram_wen,
    output word_t ram_addr,
    output word_t ram_wdata,
    input  word_t ram_rdata,
    input  logic  ram_ack,

    output logic  err
);

    arb_state_t             r_state;
    logic [DSTREAK_W-1:0]   r_dstreak;
    logic [TCNT_W-1:0]      r_tcnt;

    logic w_fetch_ok;
    logic w_starve;
    logic w_grant_d;
    logic w_grant_i;
    logic w_tc;
    logic w_granted;

    always_comb begin
        w_fetch_ok = i_req && !halt;
        w_starve   = w_fetch_ok && (r_dstreak == DSTREAK_W'(DSTREAK_MAX));
        w_grant_d  = d_req && !w_starve;
        w_grant_i  = !w_grant_d && w_fetch_ok;
        w_tc       = (r_tcnt == TCNT_W'(TIMEOUT - 1));
        w_granted  = (r_state == IGRANT) || (r_state == DGRANT);
    end

    // Acks are combinational from ram_ack; a reset in the same cycle suppresses them.
    always_comb begin
        i_ack   = !RST && (r_state == IGRANT) && ram_ack;
        d_ack   = !RST && (r_state == DGRANT) && ram_ack;
        i_rdata = i_ack ? ram_rdata : '0;
        d_rdata = d_ack ? ram_rdata : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
            r_tcnt    <= '0;
            ram_req   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= DGRANT;
                        ram_req   <= 1'b1;
                        ram_wen   <= d_wen;
                        ram_addr  <= d_addr;
                        ram_wdata <= d_wdata;
                        r_tcnt    <= '0;
                        r_dstreak <= w_fetch_ok ? sat_inc(r_dstreak) : '0;
                    end else if (w_grant_i) begin
                        r_state   <= IGRANT;
                        ram_req   <= 1'b1;
                        ram_wen   <= 1'b0;
                        ram_addr  <= i_addr;
                        r_tcnt    <= '0;
                        r_dstreak <= '0;
                    end
                end
                IGRANT, DGRANT: begin
                    // Ack takes precedence over a timeout landing in the same cycle.
                    if (ram_ack) begin
                        r_state <= GAP;
                        ram_req <= 1'b0;
                        ram_wen <= 1'b0;
                    end else if (w_tc) begin
                        r_state <= GAP;
                        ram_req <= 1'b0;
                        ram_wen <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    ram_req <= 1'b0;
                    ram_wen <= 1'b0;
                end
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_granted;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam logic [31:0] RDATA  = 32'hDEADBEEF;
    localparam logic [31:0] WDATA  = 32'h12345678;
    localparam logic [31:0] IADDR  = 32'h0000_0040;

    logic  CLK = 1'b0;
    logic  RST;
    logic  halt;
    logic  i_req;
    word_t i_addr;
    word_t i_rdata;
    logic  i_ack;
    logic  d_req;
    logic  d_wen;
    word_t d_addr;
    word_t d_wdata;
    word_t d_rdata;
    logic  d_ack;
    logic  ram_req;
    logic  ram_wen;
    word_t ram_addr;
    word_t ram_wdata;
    word_t ram_rdata;
    logic  ram_ack;
    logic  err;

    int n_chk = 0;
    int n_err = 0;

    mem_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .halt(halt),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        halt, ireq, dreq, dwen;
        logic [31:0] daddr;
        logic        rack;
        logic        e_req, e_wen, e_iack, e_dack;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic h, ir, dr, dw, input logic [31:0] da, input logic ra,
                       input logic er, ew, eia, eda, input logic [31:0] ea);
        vec_t v;
        v.halt = h; v.ireq = ir; v.dreq = dr; v.dwen = dw; v.daddr = da; v.rack = ra;
        v.e_req = er; v.e_wen = ew; v.e_iack = eia; v.e_dack = eda; v.e_addr = ea;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int cnt;
        logic saw_ack;

        RST = 1'b1; halt = 1'b0; i_req = 1'b0; i_addr = IADDR;
        d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = WDATA;
        ram_rdata = RDATA; ram_ack = 1'b0;

        // Priority: data first, then GAP, then fetch
        add(0,1,1,0,32'h100,1, 0,0,0,0,0);
        add(0,1,1,0,32'h100,1, 1,0,0,1,32'h100);
        add(0,1,0,0,32'h100,1, 0,0,0,0,0);
        add(0,1,0,0,32'h100,1, 0,0,0,0,0);
        add(0,1,0,0,32'h100,1, 1,0,1,0,IADDR);
        add(0,0,0,0,32'h100,1, 0,0,0,0,0);
        add(0,0,0,0,32'h100,1, 0,0,0,0,0);
        // Starvation bound: four data grants, one fetch, then data resumes
        for (int k = 0; k < 6; k++) begin
            add(0,1,1,0,32'h100,1, 0,0,0,0,0);
            if (k == 4) add(0,1,1,0,32'h100,1, 1,0,1,0,IADDR);
            else        add(0,1,1,0,32'h100,1, 1,0,0,1,32'h100);
            add(0,1,1,0,32'h100,1, 0,0,0,0,0);
        end
        // Halt blocks fetch but data still served
        for (int k = 0; k < 4; k++) add(1,1,0,0,32'h100,1, 0,0,0,0,0);
        add(1,1,1,0,32'h180,1, 0,0,0,0,0);
        add(1,1,1,0,32'h180,1, 1,0,0,1,32'h180);
        add(1,1,0,0,32'h180,1, 0,0,0,0,0);
        add(0,0,0,0,32'h180,1, 0,0,0,0,0);
        // Write with three wait cycles; request inputs change mid-grant
        add(0,0,1,1,32'h200,0, 0,0,0,0,0);
        add(0,0,1,1,32'h200,0, 1,1,0,0,32'h200);
        add(0,0,1,0,32'h999,0, 1,1,0,0,32'h200);
        add(0,0,1,0,32'h999,0, 1,1,0,0,32'h200);
        add(0,0,1,0,32'h999,1, 1,1,0,1,32'h200);
        add(0,0,0,0,32'h000,0, 0,0,0,0,0);
        add(0,0,0,0,32'h000,0, 0,0,0,0,0);

        tick; tick;
        @(negedge CLK);
        chk("rst ram_req", 32'(ram_req), 0);
        chk("rst ram_wen", 32'(ram_wen), 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_wdata", ram_wdata, 0);
        chk("rst acks", {30'd0, i_ack, d_ack}, 0);
        chk("rst rdata", i_rdata | d_rdata, 0);
        chk("rst err", 32'(err), 0);
        tick;
        RST = 1'b0;

        foreach (tv[i]) begin
            halt = tv[i].halt; i_req = tv[i].ireq; d_req = tv[i].dreq;
            d_wen = tv[i].dwen; d_addr = tv[i].daddr; ram_ack = tv[i].rack;
            @(negedge CLK);
            chk($sformatf("v%0d ram_req", i), 32'(ram_req), 32'(tv[i].e_req));
            chk($sformatf("v%0d ram_wen", i), 32'(ram_wen), 32'(tv[i].e_wen));
            chk($sformatf("v%0d i_ack", i), 32'(i_ack), 32'(tv[i].e_iack));
            chk($sformatf("v%0d d_ack", i), 32'(d_ack), 32'(tv[i].e_dack));
            chk($sformatf("v%0d i_rdata", i), i_rdata, tv[i].e_iack ? RDATA : 32'd0);
            chk($sformatf("v%0d d_rdata", i), d_rdata, tv[i].e_dack ? RDATA : 32'd0);
            if (tv[i].e_req)
                chk($sformatf("v%0d ram_addr", i), ram_addr, tv[i].e_addr);
            if (tv[i].e_wen)
                chk($sformatf("v%0d ram_wdata", i), ram_wdata, WDATA);
            chk($sformatf("v%0d err", i), 32'(err), 0);
            tick;
        end

        // Timeout: RAM never acks
        halt = 1'b0; i_req = 1'b0; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h300; ram_ack = 1'b0;
        @(negedge CLK);
        chk("to idle ram_req", 32'(ram_req), 0);
        cnt = 0; saw_ack = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick;
            @(negedge CLK);
            if (i_ack || d_ack) saw_ack = 1'b1;
            if (!ram_req) break;
            cnt++;
        end
        d_req = 1'b0;
        chk("to granted cycles", cnt, 8);
        chk("to no ack", 32'(saw_ack), 0);
        chk("to err set", 32'(err), 1);
        for (int n = 0; n < 3; n++) begin
            tick;
            @(negedge CLK);
            chk("to err sticky", 32'(err), 1);
            chk("to acks idle", {30'd0, i_ack, d_ack}, 0);
        end
        tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        @(negedge CLK);
        chk("to err cleared", 32'(err), 0);

        // Reset in the second DGRANT cycle
        tick;
        d_req = 1'b1; d_addr = 32'h400; ram_ack = 1'b0;
        tick;
        @(negedge CLK);
        chk("mr grant1 ram_req", 32'(ram_req), 1);
        tick;
        RST = 1'b1; ram_ack = 1'b1;
        @(negedge CLK);
        chk("mr no d_ack", 32'(d_ack), 0);
        tick;
        RST = 1'b0; d_req = 1'b0; ram_ack = 1'b0;
        @(negedge CLK);
        chk("mr ram_req", 32'(ram_req), 0);
        chk("mr ram_addr", ram_addr, 0);
        chk("mr ram_wdata", ram_wdata, 0);
        chk("mr acks", {30'd0, i_ack, d_ack}, 0);
        tick;
        d_req = 1'b1; d_addr = 32'h404; ram_ack = 1'b1;
        tick;
        @(negedge CLK);
        chk("mr regrant ram_req", 32'(ram_req), 1);
        chk("mr regrant addr", ram_addr, 32'h404);
        chk("mr regrant d_ack", 32'(d_ack), 1);
        chk("mr regrant d_rdata", d_rdata, RDATA);
        tick;
        d_req = 1'b0; ram_ack = 1'b0;
        @(negedge CLK);
        chk("mr gap ram_req", 32'(ram_req), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the fetch path (instruction reads) and the memory stage (data reads/writes). It serializes both onto the one RAM port, gives data priority with a bounded-starvation rule for fetch, and blocks fetches once the pipeline's halt reaches the MEM/WB boundary. It also flags RAM accesses that never complete.

## Interface
- `DSTREAK_MAX`, default 4: consecutive data grants allowed while a fetch waits; the next grant then goes to fetch.
- `TIMEOUT`, default 255: cycles a granted access may wait for `ram_ack` before it is aborted.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `halt` in 1: halt seen at writeback; once high, no new fetch grants.
- `i_req` in 1: fetch request; held until `i_ack`.
- `i_addr` in 32 (`word_t`): fetch address.
- `i_rdata` out 32: fetch data; valid only with `i_ack`.
- `i_ack` out 1: fetch completes this cycle.
- `d_req` in 1: data request; held until `d_ack`.
- `d_wen` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data; valid only with `d_ack`.
- `d_ack` out 1: data access completes this cycle.
- `ram_req` out 1: access in progress.
- `ram_wen` out 1: access is a write.
- `ram_addr` out 32: latched address.
- `ram_wdata` out 32: latched store data.
- `ram_rdata` in 32: read data, valid with `ram_ack`.
- `ram_ack` in 1: RAM completes the current access.
- `err` out 1: sticky timeout flag.

## Operation
- States (`arb_state_t`): IDLE, IGRANT, DGRANT, GAP.
- IDLE:
  - A data request is granted (go to DGRANT) when `d_req`=1, unless `i_req`=1 and `!halt` and `dstreak == DSTREAK_MAX`.
  - Otherwise a fetch is granted (go to IGRANT) when `i_req`=1 and `!halt`.
  - Otherwise the arbiter stays in IDLE.
  - On grant, the arbiter latches `addr`, `wdata` and `wen` into the RAM output registers. On a fetch grant, `ram_wen` is forced to 0.
- IGRANT/DGRANT:
  - `ram_req`=1, with RAM outputs stable for the whole access.
  - On `ram_ack`, the owner's ack is 1 and `ram_rdata` passes combinationally to the owner's rdata. The state then goes to GAP.
- GAP: one bubble cycle with all acks 0 and `ram_req`=0, so requesters can drop or change their request. Always goes to IDLE.
- `dstreak` (3-bit saturating counter):
  - Increments on a data grant made while `i_req`=1 and `!halt`.
  - Clears on a fetch grant, and clears whenever a data grant is made with no fetch pending.
- Timeout counter (8 bits, wide enough for `TIMEOUT`):
  - Cleared on entry to IGRANT or DGRANT; increments each granted cycle without `ram_ack`.
  - On reaching `TIMEOUT`, `err` is set, `ram_req` drops, and the state goes to GAP with no ack issued. The requester stays stalled.
  - `err` clears only on `RST`.
- A requester that drops its request mid-grant does not cancel the access. The access completes and the ack pulse is still issued.
- `halt` rising during IGRANT does not abort that fetch.
- Simultaneous `ram_ack` and timeout terminal count: the ack wins and `err` is not set.

## Timing
- Reset values (all outputs): `ram_req`, `ram_wen`, `i_ack`, `d_ack`, `err` = 0. `ram_addr`, `ram_wdata`, `i_rdata`, `d_rdata` = 0. State = IDLE, `dstreak` = 0.
- `RST` during a grant abandons the access: outputs return to reset values at the next edge and no ack is issued.
- Latency:
  - Request seen in IDLE at cycle t; `ram_req` high from t+1.
  - With `ram_ack` at cycle a (a ≥ t+1), the ack is in cycle a, GAP at a+1, and IDLE at a+2.
  - Minimum request-to-ack is 1 cycle. Back-to-back throughput is one access per 3 cycles with a zero-wait RAM.
- All acks are single-cycle pulses. At most one ack is high in any cycle.

## Structure
- `cpu_types_pkg` holds `arb_state_t` (2-bit enum) alongside `word_t`.
- No sub-module; the arbiter is one module with a single sequential block and a next-state/output combinational block.
- `DSTREAK_MAX` is at most 7, so `dstreak` fits in 3 bits.

## Test plan
- Data priority with zero-wait RAM:
  - Stimulus: `i_req` and `d_req` both high in the same cycle, `d_addr`=0x100 read, `ram_rdata`=0xDEADBEEF.
  - Response: DGRANT first and `d_ack` with `d_rdata`=0xDEADBEEF. Then GAP, then IGRANT on `i_addr`.
- Starvation bound: `d_req` held continuously and `i_req` high, `DSTREAK_MAX`=4 → 4 data grants, then 1 fetch grant, then data resumes.
- Write path:
  - Stimulus: `d_wen`=1, `d_addr`=0x200, `d_wdata`=0x12345678, `ram_ack` after 3 wait cycles.
  - Response: `ram_wen`=1 with stable addr/data for 4 cycles, then `d_ack` for one cycle.
- Halt blocking: `halt`=1 with `i_req`=1 and no `d_req` → `ram_req` stays 0 indefinitely. A `d_req` is still served.
- Timeout: grant issued and `ram_ack` never asserted, `TIMEOUT`=8 → `ram_req` drops after 8 granted cycles, `err`=1 sticky, and no ack pulses.
- Reset mid-access: `RST` asserted in the second DGRANT cycle → next cycle all outputs are 0, no `d_ack`, and a fresh request is granted normally after `RST` drops.
